// File: rtl/clk_freq_monitor.sv
// Multi-channel frequency qualifier: counts toggle edges over a fixed reference gate,
// checks each count against min/max limits and tracks valid/lost with hysteresis.
module clk_freq_monitor #(
  parameter int CH        = 2,
  parameter int GATE_W    = 12,
  parameter int CNT_W     = 16,
  parameter int QUAL_N    = 100,
  parameter int DISQUAL_N = 2
) (
  input  logic                clk_10mhz_ext_bufg,
  input  logic                rst_250mhz_int,
  input  logic [CH-1:0]       enable,
  input  logic [CH-1:0]       toggle_in,
  input  logic [CH*CNT_W-1:0] min_count,
  input  logic [CH*CNT_W-1:0] max_count,
  input  logic [CH-1:0]       clear_lost,
  output logic [CH*CNT_W-1:0] freq_count,
  output logic                count_update,
  output logic [CH-1:0]       freq_valid,
  output logic [CH-1:0]       freq_lost
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [15:0]      QUAL_L  = 16'(QUAL_N);
  localparam logic [7:0]       DISQ_L  = 8'(DISQUAL_N);

  typedef enum logic [1:0] {
    ST_INVALID,
    ST_QUALIFY,
    ST_VALID,
    ST_DEGRADED
  } state_t;

  // Reset asserts immediately, releases two reference edges later.
  logic [1:0] rst_pipe_reg;
  logic       rst_sync;

  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_250mhz_int) begin
    if (rst_250mhz_int) begin
      rst_pipe_reg <= 2'b11;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b0};
    end
  end

  assign rst_sync = rst_pipe_reg[1];

  // Shared gate timer; the gate never stretches.
  logic [GATE_W-1:0] gate_cnt_reg;
  logic              gate_end;

  assign gate_end = &gate_cnt_reg;

  always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_sync) begin
    if (rst_sync) begin
      gate_cnt_reg <= '0;
      count_update <= 1'b0;
    end else begin
      gate_cnt_reg <= gate_cnt_reg + GATE_W'(1);
      count_update <= gate_end;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [2:0]       sync_reg;
    logic             hist_reg;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] next_count;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] min_l;
    logic [CNT_W-1:0] max_l;
    logic             good;
    state_t           state_reg;
    logic [15:0]      qcnt_reg;
    logic [7:0]       dcnt_reg;
    logic             valid_reg;
    logic             lost_reg;

    assign min_l = min_count[gi*CNT_W +: CNT_W];
    assign max_l = max_count[gi*CNT_W +: CNT_W];

    always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_sync) begin
      if (rst_sync) begin
        sync_reg <= '0;
        hist_reg <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[1:0], toggle_in[gi]};
        hist_reg <= sync_reg[2];
      end
    end

    assign edge_det = sync_reg[2] ^ hist_reg;

    // Count includes any edge arriving in the gate_end cycle itself.
    always_comb begin
      next_count = cnt_reg;
      if (!enable[gi]) begin
        next_count = '0;
      end else if (edge_det && (cnt_reg != CNT_MAX)) begin
        next_count = cnt_reg + CNT_W'(1);
      end
    end

    assign good = enable[gi] && (min_l <= next_count) && (next_count <= max_l);

    always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_sync) begin
      if (rst_sync) begin
        cnt_reg   <= '0;
        count_reg <= '0;
      end else begin
        cnt_reg <= gate_end ? '0 : next_count;
        if (gate_end) begin
          count_reg <= next_count;
        end
      end
    end

    // Loss is assigned after the clear so a simultaneous set takes priority.
    always_ff @(posedge clk_10mhz_ext_bufg or posedge rst_sync) begin
      if (rst_sync) begin
        state_reg <= ST_INVALID;
        qcnt_reg  <= '0;
        dcnt_reg  <= '0;
        valid_reg <= 1'b0;
        lost_reg  <= 1'b0;
      end else begin
        if (clear_lost[gi]) begin
          lost_reg <= 1'b0;
        end
        if (!enable[gi]) begin
          state_reg <= ST_INVALID;
          qcnt_reg  <= '0;
          dcnt_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (gate_end) begin
          case (state_reg)
            ST_INVALID: begin
              if (good) begin
                if (QUAL_N == 1) begin
                  state_reg <= ST_VALID;
                  valid_reg <= 1'b1;
                end else begin
                  state_reg <= ST_QUALIFY;
                  qcnt_reg  <= 16'd1;
                end
              end
            end
            ST_QUALIFY: begin
              if (!good) begin
                state_reg <= ST_INVALID;
                qcnt_reg  <= '0;
              end else if (qcnt_reg + 16'd1 == QUAL_L) begin
                state_reg <= ST_VALID;
                valid_reg <= 1'b1;
                qcnt_reg  <= '0;
              end else begin
                qcnt_reg <= qcnt_reg + 16'd1;
              end
            end
            ST_VALID: begin
              if (!good) begin
                if (DISQUAL_N == 1) begin
                  state_reg <= ST_INVALID;
                  valid_reg <= 1'b0;
                  lost_reg  <= 1'b1;
                end else begin
                  state_reg <= ST_DEGRADED;
                  dcnt_reg  <= 8'd1;
                end
              end
            end
            ST_DEGRADED: begin
              if (good) begin
                state_reg <= ST_VALID;
                dcnt_reg  <= '0;
              end else if (dcnt_reg + 8'd1 == DISQ_L) begin
                state_reg <= ST_INVALID;
                valid_reg <= 1'b0;
                lost_reg  <= 1'b1;
                dcnt_reg  <= '0;
              end else begin
                dcnt_reg <= dcnt_reg + 8'd1;
              end
            end
            default: begin
              state_reg <= ST_INVALID;
              valid_reg <= 1'b0;
              qcnt_reg  <= '0;
              dcnt_reg  <= '0;
            end
          endcase
        end
      end
    end

    assign freq_count[gi*CNT_W +: CNT_W] = count_reg;
    assign freq_valid[gi]                = valid_reg;
    assign freq_lost[gi]                 = lost_reg;
  end

endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Parametrised multi-channel frequency qualifier clocked by the external 10 MHz reference. It counts edges of up to CH low-rate toggle signals over a fixed gate of 2^GATE_W reference cycles and checks each count against per-channel min/max limits. Each channel has a qualify/disqualify hysteresis state machine, a validity flag and a sticky loss flag. It supports reference-switching decisions and health reporting for the clock management logic.

## Interface
- CH, 2: number of monitored channels
- GATE_W, 12: gate length is 2^GATE_W clk cycles
- CNT_W, 16: edge counter / limit width
- QUAL_N, 100: consecutive good gates required to assert valid (1..65535)
- DISQUAL_N, 2: consecutive bad gates required to drop valid (1..255)

- clk_10mhz_ext_bufg  in  1  clock
- rst_250mhz_int  in  1  reset, asynchronous, active-high
- enable  in  CH  per-channel enable
- toggle_in  in  CH  monitored toggle signals, asynchronous; edge rate < clk/2
- min_count  in  CH*CNT_W  inclusive lower limit, channel i at [i*CNT_W +: CNT_W], quasi-static
- max_count  in  CH*CNT_W  inclusive upper limit, same packing
- clear_lost  in  CH  per-channel pulse, clears freq_lost
- freq_count  out  CH*CNT_W  count from the last completed gate
- count_update  out  1  one-cycle pulse at each gate end
- freq_valid  out  CH  channel qualified
- freq_lost  out  CH  sticky: channel lost qualification

## Operation
- Reset: assertion is asynchronous. Deassertion is synchronised through a 2-flop chain in the clk domain (rst_sync). All state and outputs are 0 while rst_sync is high.
- Input path: toggle_in goes through a 3-flop synchroniser plus one history flop. edge[i] = sync3 ^ hist.
- Gate counter: GATE_W bits, free-running from 0. gate_end when the counter is all-ones; then wraps to 0. All channels share this counter.
- Edge counter per channel:
  - Increments on edge and saturates at 2^CNT_W-1.
  - On gate_end, next_count (including any edge in the gate_end cycle) is latched into freq_count and the counter clears to 0.
  - When enable[i]=0, the counter is held at 0.
- good[i] = enable[i] & (min <= next_count <= max), evaluated only at gate_end.
- FSM per channel, transitions only at gate_end except for disable:
  - INVALID (valid 0):
    - good with QUAL_N=1 -> VALID.
    - good otherwise -> QUALIFY, qcnt=1.
    - bad -> stay.
  - QUALIFY (valid 0):
    - good -> qcnt+1; if qcnt+1==QUAL_N -> VALID.
    - bad -> INVALID, qcnt=0.
  - VALID (valid 1):
    - good -> stay.
    - bad with DISQUAL_N=1 -> INVALID and set lost.
    - bad otherwise -> DEGRADED, dcnt=1.
  - DEGRADED (valid 1):
    - good -> VALID, dcnt=0.
    - bad -> dcnt+1; if dcnt+1==DISQUAL_N -> INVALID and set lost.
  - enable[i]=0: forced to INVALID in the next cycle, counters cleared, lost not set.
- freq_lost: set on the VALID/DEGRADED -> INVALID transition caused by bad gates, cleared by clear_lost. If set and clear occur in the same cycle, set wins.
- Width rules:
  - qcnt is 16 bits; dcnt is 8 bits.
  - Comparisons are unsigned CNT_W.
  - min > max means every gate is bad.

## Timing
- All outputs are registered. Reset value of every output is 0.
- toggle_in edge to edge-counter increment: 4-5 cycles latency (synchroniser uncertainty).
- count_update, freq_count, freq_valid and freq_lost all update on the same clock edge, the one following the gate_end cycle.
- First count_update comes 2^GATE_W cycles after rst_sync deasserts, i.e. 2^GATE_W+2 cycles after rst_250mhz_int falls.
- Gate period is exactly 2^GATE_W cycles and never stretches.
- Reset mid-gate aborts the gate; no count_update is issued for the partial gate.
- enable falling mid-gate: freq_valid falls on the next cycle. The channel's freq_count is 0 at the next gate_end.
- enable rising mid-gate: counting starts on the next cycle, so the first gate is partial and normally bad.

## Test plan
- Reset: hold rst_250mhz_int, toggle inputs -> all outputs 0. Release -> first count_update exactly 4098 cycles later.
- Nominal qualify: QUAL_N=4, toggle_in[0] flips every 4 clk cycles, limits 1014..1034:
  - freq_count[0] = 1024 (±1 on the first gate).
  - freq_valid[0] rises with the 4th count_update; freq_lost stays 0.
- Hysteresis: DISQUAL_N=2 in VALID, one gate with toggling stopped, then resume:
  - freq_count = 0 for that gate, freq_valid stays 1.
  - Stop for 2 gates -> freq_valid falls and freq_lost rises at the 2nd count_update.
- Saturation: CNT_W=8, toggle every 2 cycles -> freq_count = 255 (not 2048 mod 256). With limits 0..254 the gate is bad.
- Clear/set collision: assert clear_lost in the same cycle freq_lost is set -> freq_lost = 1. A later isolated clear_lost -> 0 next cycle.
- Disable mid-gate with channel 1 VALID -> freq_valid[1] = 0 next cycle, freq_lost[1] = 0, freq_count[1] = 0 at gate end. Channel 0 is unaffected.
